// File: rtl/codificador_display_scan.sv
// Time-multiplexed hex display driver: a strobed word is held pending and committed at the scan-frame wrap.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module codificador_display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Input,
  input  logic                  Ready,
  output logic                  Loaded,
  output logic                  Pending,
  output logic [DIGITS-1:0]     Anode,
  output logic [6:0]            Display
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PRESCALE - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                loaded_q, loaded_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          display_q, display_d;

  logic                tick;
  logic                commit_point;
  logic [3:0]          nib_sel;
  logic                blank_sel;
  logic [DIGITS-1:0]   blank_vec;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Prescaler and scan index; the frame wraps on the tick seen at the last digit.
  always_comb begin
    tick         = (presc_q == LAST_PRE);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    commit_point = tick && (idx_q == LAST_IDX);
  end

  // Load FSM: the old buffer is committed at the wrap even if a new word arrives that cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    buf_d    = buf_q;
    active_d = active_q;
    loaded_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Ready) begin
          buf_d   = Input;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (commit_point) begin
          active_d = buf_q;
          loaded_d = 1'b1;
          state_d  = Ready ? HOLD : IDLE;
        end
        if (Ready) buf_d = Input;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit selection, optional leading-zero blanking, and registered output stage.
  always_comb begin
    logic all_zero;
    nib_sel   = '0;
    blank_vec = '0;
    anode_d   = '0;
    all_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (active_q[4*k +: 4] == 4'h0);
      blank_vec[k] = all_zero && (k != 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_sel    = active_q[4*k +: 4];
        anode_d[k] = 1'b1;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) blank_sel = blank_vec[k];
    end
`else
    blank_sel = 1'b0;
`endif
    display_d = blank_sel ? 7'b0000000 : seg7(nib_sel);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
      state_q   <= IDLE;
      presc_q   <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      active_q  <= '0;
      loaded_q  <= 1'b0;
      anode_q   <= '0;
      display_q <= 7'b0000000;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      active_q  <= active_d;
      loaded_q  <= loaded_d;
      anode_q   <= anode_d;
      display_q <= display_d;
    end
  end

  assign Loaded  = loaded_q;
  assign Pending = (state_q == HOLD);
  assign Anode   = anode_q;
  assign Display = display_q;

endmodule

// File: tb/tb_codificador_display_scan.sv
// Directed bench for codificador_display_scan with DIGITS=4, PRESCALE=4 (16-cycle frames).
module tb_codificador_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        ready;
  logic        loaded;
  logic        pending;
  logic [3:0]  anode;
  logic [6:0]  display;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int loaded_seen = 0;

  codificador_display_scan #(.DIGITS(4), .PRESCALE(4)) dut (
    .Clock  (clk),
    .Reset  (rst),
    .Input  (din),
    .Ready  (ready),
    .Loaded (loaded),
    .Pending(pending),
    .Anode  (anode),
    .Display(display)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     word;
    logic [3:0][6:0] seg;  // seg[d] = expected segments of digit d
  } vec_t;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] SA = 7'b1110111, SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111;
  localparam logic [6:0] SF = 7'b1000111, SB = 7'b0000000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (loaded === 1'b1) loaded_seen++;
  endtask

  task automatic load(input logic [15:0] w);
    ready = 1'b1;
    din   = w;
    step();
    ready = 1'b0;
  endtask

  task automatic to_commit();
    while (cyc % 16 != 0) step();
  endtask

  // Runs one full frame starting right after a commit edge, checking each digit once.
  task automatic frame_check(input string name, input logic [3:0][6:0] exp);
    int d;
    for (int s = 0; s < 16; s++) begin
      step();
      if (s == 0) check({name, " loaded_drop"}, 32'(loaded), 32'd0);
      if ((cyc - 1) % 4 == 0) begin
        d = ((cyc - 1) / 4) % 4;
        check({name, " anode"}, 32'(anode), 32'(4'b0001 << d));
        check({name, " display"}, 32'(display), 32'(exp[d]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " anode"},   32'(anode),   32'd0);
    check({name, " display"}, 32'(display), 32'd0);
    check({name, " loaded"},  32'(loaded),  32'd0);
    check({name, " pending"}, 32'(pending), 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    int base;
    vecs[0] = '{word: 16'h12AF, seg: {S1, S2, SA, SF}};
    vecs[1] = '{word: 16'hC5E6, seg: {SC, S5, SE, S6}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[2] = '{word: 16'h0070, seg: {SB, SB, S7, S0}};
    vecs[3] = '{word: 16'h0D04, seg: {SB, SD, S0, S4}};
    vecs[4] = '{word: 16'h0000, seg: {SB, SB, SB, S0}};
`else
    vecs[2] = '{word: 16'h0070, seg: {S0, S0, S7, S0}};
    vecs[3] = '{word: 16'h0D04, seg: {S0, SD, S0, S4}};
    vecs[4] = '{word: 16'h0000, seg: {S0, S0, S0, S0}};
`endif

    rst = 1'b1; ready = 1'b0; din = '0;
    step();
    step();
    check_reset_outputs("reset");

    // Idle scan after release: one-hot walk, all digits show 0, no Loaded.
    rst = 1'b0;
    cyc = 0;
    loaded_seen = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      check("idle anode", 32'(anode), 32'(4'b0001 << (((cyc - 1) / 4) % 4)));
      check("idle display", 32'(display), 32'(S0));
    end
    check("idle no loaded", 32'(loaded_seen), 32'd0);

    // Table: capture, commit at the frame wrap, then verify the full frame.
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].word);
      check("vec pending set", 32'(pending), 32'd1);
      to_commit();
      check("vec loaded", 32'(loaded), 32'd1);
      check("vec pending clr", 32'(pending), 32'd0);
      frame_check($sformatf("vec%0d", i), vecs[i].seg);
    end

    // Last write wins before the commit point; exactly one Loaded pulse.
    base = loaded_seen;
    load(16'h1111);
    load(16'h2222);
    to_commit();
    check("overwrite loaded", 32'(loaded), 32'd1);
    frame_check("overwrite", {S2, S2, S2, S2});
    check("overwrite pulses", 32'(loaded_seen - base), 32'd1);

    // Ready in the commit cycle: old buffer commits, new word stays pending.
    load(16'h4444);
    while (cyc % 16 != 15) step();
    ready = 1'b1;
    din   = 16'h3333;
    step();
    ready = 1'b0;
    check("rdy@commit loaded", 32'(loaded), 32'd1);
    check("rdy@commit pending", 32'(pending), 32'd1);
    frame_check("rdy@commit first", {S4, S4, S4, S4});
    check("rdy@commit 2nd loaded", 32'(loaded), 32'd1);
    check("rdy@commit 2nd pending", 32'(pending), 32'd0);
    frame_check("rdy@commit second", {S3, S3, S3, S3});

    // Reset while a word is pending: discarded, no Loaded, display back to zeros.
    load(16'h5555);
    check("mid pending", 32'(pending), 32'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("mid reset");
    rst = 1'b0;
    cyc = 0;
    base = loaded_seen;
    for (int n = 0; n < 40; n++) begin
      step();
      if ((cyc - 1) % 4 == 0) begin
        check("post reset anode", 32'(anode), 32'(4'b0001 << (((cyc - 1) / 4) % 4)));
        check("post reset display", 32'(display), 32'(S0));
      end
    end
    check("post reset no loaded", 32'(loaded_seen - base), 32'd0);
    check("post reset pending", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
